// File: rtl/pipelined_adder_pkg.sv
// Shared defaults and helpers for the chunked pipelined adder.
package pipelined_adder_pkg;

    localparam int N_DEFAULT      = 16;
    localparam int STAGES_DEFAULT = 4;

    function automatic int chunk_w(input int n, input int stages);
        return n / stages;
    endfunction

endpackage

// File: rtl/pipelined_adder_stage.sv
// One chunk of the pipelined adder: registered W-bit sum plus carry-out.
// Latency 1 cycle. It holds its registers while en is low.
module adder_stage
    import pipelined_adder_pkg::*;
#(
    parameter int W = chunk_w(N_DEFAULT, STAGES_DEFAULT)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    logic [W:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s    <= '0;
            cout <= 1'b0;
        end else if (en) begin
            s    <= full[W-1:0];
            cout <= full[W];
        end
    end

endmodule

// File: rtl/pipelined_adder.sv
// Carry-chunked adder: A+B+Cin split over STAGES registered chunks; optional Ovf under PIPELINED_ADDER_OVF_EN.
// Latency is STAGES cycles from the accept cycle to out_valid, with a throughput of one result per cycle.
// A stalled output freezes the whole pipe, and in_ready drops whenever out_valid is held by out_ready low.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int N      = N_DEFAULT,
    parameter int STAGES = STAGES_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] Sum,
    output logic         Cout,
    output logic         out_valid,
`ifdef PIPELINED_ADDER_OVF_EN
    output logic         Ovf,
`endif
    input  logic         out_ready
);

    localparam int W = chunk_w(N, STAGES);

    logic              en;
    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] carry;
    logic [STAGES-1:0] stg_cin;
    logic [W-1:0]      stg_a   [STAGES];
    logic [W-1:0]      stg_b   [STAGES];
    logic [W-1:0]      stg_sum [STAGES];
    logic [N-1:0]      sum_dat;

    assign out_valid = vld[STAGES-1];
    assign in_ready  = !(out_valid && !out_ready);
    assign en        = in_ready;
    assign Sum       = sum_dat;
    assign Cout      = carry[STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
        end else if (en) begin
            vld[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                vld[k] <= vld[k-1];
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign stg_a[k]   = A[W-1:0];
            assign stg_b[k]   = B[W-1:0];
            assign stg_cin[k] = Cin;
        end else begin : g_skew
            // Chunk k meets its carry k cycles after acceptance, so its operands wait k cycles.
            logic [W-1:0] dly_a [k];
            logic [W-1:0] dly_b [k];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int d = 0; d < k; d++) begin
                        dly_a[d] <= '0;
                        dly_b[d] <= '0;
                    end
                end else if (en) begin
                    dly_a[0] <= A[k*W +: W];
                    dly_b[0] <= B[k*W +: W];
                    for (int d = 1; d < k; d++) begin
                        dly_a[d] <= dly_a[d-1];
                        dly_b[d] <= dly_b[d-1];
                    end
                end
            end

            assign stg_a[k]   = dly_a[k-1];
            assign stg_b[k]   = dly_b[k-1];
            assign stg_cin[k] = carry[k-1];
        end

        adder_stage #(
            .W(W)
        ) u_stage (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .a    (stg_a[k]),
            .b    (stg_b[k]),
            .cin  (stg_cin[k]),
            .s    (stg_sum[k]),
            .cout (carry[k])
        );

        if (k == STAGES-1) begin : g_last
            assign sum_dat[k*W +: W] = stg_sum[k];
        end else begin : g_deskew
            // Early chunks finish first and wait here until the top chunk catches up.
            logic [W-1:0] dly_s [STAGES-1-k];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int d = 0; d < STAGES-1-k; d++) begin
                        dly_s[d] <= '0;
                    end
                end else if (en) begin
                    dly_s[0] <= stg_sum[k];
                    for (int d = 1; d < STAGES-1-k; d++) begin
                        dly_s[d] <= dly_s[d-1];
                    end
                end
            end

            assign sum_dat[k*W +: W] = dly_s[STAGES-2-k];
        end
    end

`ifdef PIPELINED_ADDER_OVF_EN
    logic [W:0] last_full;
    logic       ovf_nxt;

    assign last_full = {1'b0, stg_a[STAGES-1]} + {1'b0, stg_b[STAGES-1]}
                     + {{W{1'b0}}, stg_cin[STAGES-1]};
    // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
    assign ovf_nxt   = stg_a[STAGES-1][W-1] ^ stg_b[STAGES-1][W-1]
                     ^ last_full[W-1] ^ last_full[W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Ovf <= 1'b0;
        end else if (en) begin
            Ovf <= ovf_nxt;
        end
    end
`endif

endmodule
